// File: rtl/led_flasher.sv
// LED driver: turns single-cycle event strobes into visible flashes, with steady,
// blink and PWM-dimmed modes. LED, BUSY and PEND are all registered outputs.
module led_flasher #(
    parameter int HOLD_W  = 16,
    parameter int BLINK_W = 20,
    parameter int PWM_W   = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EV,
    input  logic [1:0]       MODE,
    input  logic [PWM_W-1:0] BRIGHT,
    output logic             LED,
    output logic             BUSY,
    output logic [1:0]       PEND,
    output logic [1:0]       STATE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0]  HOLD_MAX  = {HOLD_W{1'b1}};
    localparam logic [BLINK_W-1:0] BLINK_MAX = {BLINK_W{1'b1}};

    state_t             state, state_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_n;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [1:0]         pend_n, pend_inc, eff;
    logic               pwm_on, enable;

    assign STATE    = state;
    assign pwm_on   = (pwm_cnt < BRIGHT);
    assign pend_inc = (PEND == 2'd3) ? 2'd3 : PEND + 2'd1;
    assign eff      = EV ? pend_inc : PEND;

    always_comb begin
        enable = 1'b0;
        case (MODE)
            2'b00:   enable = 1'b0;
            2'b01:   enable = 1'b1;
            2'b10:   enable = (state == HOLD);
            default: enable = blink_phase;
        endcase
    end

    // Next-state for the flash engine; leaving flash mode abandons any queued work.
    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        pend_n  = PEND;
        if (MODE != 2'b10) begin
            state_n = IDLE;
            hold_n  = '0;
            pend_n  = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (EV) begin
                        state_n = HOLD;
                        hold_n  = '0;
                    end
                end
                HOLD: begin
                    hold_n = hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_MAX) state_n = GAP;
                    if (EV) pend_n = pend_inc;
                end
                GAP: begin
                    if (hold_cnt == HOLD_MAX) begin
                        // An event landing on the last gap cycle chains straight into a flash.
                        hold_n = '0;
                        if (eff != 2'd0) begin
                            state_n = HOLD;
                            pend_n  = eff - 2'd1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                        if (EV) pend_n = pend_inc;
                    end
                end
                default: begin
                    state_n = IDLE;
                    hold_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            PEND        <= 2'd0;
            BUSY        <= 1'b0;
            LED         <= 1'b0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            LED      <= enable & pwm_on;
            state    <= state_n;
            hold_cnt <= hold_n;
            PEND     <= pend_n;
            BUSY     <= (state_n != IDLE) | (pend_n != 2'd0);
            if (MODE == 2'b11) begin
                blink_cnt <= blink_cnt + 1'b1;
                if (blink_cnt == BLINK_MAX) blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_flasher.sv
// Bench for led_flasher: directed scenarios plus random mode/event segments,
// checked cycle by cycle against a timeline-based reference model.
module tb_led_flasher;

    localparam int HOLD_W  = 3;
    localparam int BLINK_W = 3;
    localparam int PWM_W   = 2;
    localparam int H = 1 << HOLD_W;
    localparam int B = 1 << BLINK_W;
    localparam int P = 1 << PWM_W;

    logic             CLK;
    logic             RST;
    logic             EV;
    logic [1:0]       MODE;
    logic [PWM_W-1:0] BRIGHT;
    logic             LED;
    logic             BUSY;
    logic [1:0]       PEND;
    logic [1:0]       STATE;

    led_flasher #(.HOLD_W(HOLD_W), .BLINK_W(BLINK_W), .PWM_W(PWM_W)) dut (
        .CLK(CLK), .RST(RST), .EV(EV), .MODE(MODE), .BRIGHT(BRIGHT),
        .LED(LED), .BUSY(BUSY), .PEND(PEND), .STATE(STATE)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [3:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: elapsed cycles since reset, position within the current
    // flash+gap window (-1 when idle), queued events and time spent blinking.
    int m_cyc;
    int m_flash;
    int m_pend;
    int m_blink;

    task automatic model_reset();
        m_cyc   = 0;
        m_flash = -1;
        m_pend  = 0;
        m_blink = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // driver: one cycle of stimulus, model advanced and expectation queued
    task automatic drive(input logic ev, input logic [1:0] mode, input int bright);
        logic       en, led_e, busy_e;
        logic [1:0] pend_e;
        int         eff;
        @(negedge CLK);
        RST    = 1'b0;
        EV     = ev;
        MODE   = mode;
        BRIGHT = bright[PWM_W-1:0];
        case (mode)
            2'd0:    en = 1'b0;
            2'd1:    en = 1'b1;
            2'd2:    en = (m_flash >= 0) && (m_flash < H);
            default: en = ((m_blink / B) % 2) == 1;
        endcase
        led_e = en && ((m_cyc % P) < bright);
        if (mode == 2'd3) m_blink++;
        else m_blink = 0;
        if (mode != 2'd2) begin
            m_flash = -1;
            m_pend  = 0;
        end else if (m_flash < 0) begin
            if (ev) m_flash = 0;
        end else if (m_flash == 2 * H - 1) begin
            eff = m_pend + int'(ev);
            if (eff > 3) eff = 3;
            if (eff > 0) begin
                m_flash = 0;
                m_pend  = eff - 1;
            end else begin
                m_flash = -1;
            end
        end else begin
            m_flash++;
            if (ev && m_pend < 3) m_pend++;
        end
        m_cyc++;
        busy_e = (m_flash >= 0) || (m_pend > 0);
        pend_e = m_pend[1:0];
        exp_q.push_back({led_e, busy_e, pend_e});
    endtask

    // Raise RST between edges; outputs must clear before the next clock edge.
    task automatic async_reset();
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("async_rst_led", int'(LED), 0);
        check("async_rst_busy", int'(BUSY), 0);
        check("async_rst_pend", int'(PEND), 0);
        model_reset();
        exp_q.push_back(4'b0000);
    endtask

    task automatic run_seg(input logic [1:0] mode, input int bright, input int len, input int ev_pct);
        for (int i = 0; i < len; i++)
            drive($urandom_range(99, 0) < ev_pct, mode, bright);
    endtask

    // monitor / scoreboard
    always @(posedge CLK) begin
        logic [3:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("led", int'(LED), int'(e[3]));
            check("busy", int'(BUSY), int'(e[2]));
            check("pend", int'(PEND), int'(e[1:0]));
        end
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int ev_tab[3];
        logic [1:0] mode;
        ev_tab[0] = 2;
        ev_tab[1] = 10;
        ev_tab[2] = 40;
        RST    = 1'b1;
        EV     = 1'b0;
        MODE   = 2'b00;
        BRIGHT = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        #1;
        check("reset_led", int'(LED), 0);
        check("reset_busy", int'(BUSY), 0);
        check("reset_pend", int'(PEND), 0);
        check("reset_state", int'(STATE), 0);

        // reset in the middle of a flash, then quiet flash mode stays dark
        drive(1'b1, 2'd2, 3);
        repeat (3) drive(1'b0, 2'd2, 3);
        async_reset();
        repeat (10) drive(1'b0, 2'd2, 3);

        // single flash
        drive(1'b1, 2'd2, 3);
        repeat (20) drive(1'b0, 2'd2, 3);

        // five events while holding: queue saturates, four flashes in total
        drive(1'b1, 2'd2, 3);
        drive(1'b0, 2'd2, 3);
        repeat (5) drive(1'b1, 2'd2, 3);
        repeat (70) drive(1'b0, 2'd2, 3);

        // event on the last gap cycle chains directly into the next flash
        drive(1'b1, 2'd2, 3);
        repeat (15) drive(1'b0, 2'd2, 3);
        drive(1'b1, 2'd2, 3);
        repeat (20) drive(1'b0, 2'd2, 3);

        repeat (40) drive(1'b0, 2'd3, 2);
        repeat (10) drive(1'b0, 2'd1, 0);

        // drop out of flash mode with two events queued
        drive(1'b1, 2'd2, 3);
        drive(1'b0, 2'd2, 3);
        drive(1'b1, 2'd2, 3);
        drive(1'b1, 2'd2, 3);
        drive(1'b0, 2'd2, 3);
        repeat (6) drive(1'b0, 2'd0, 3);

        for (int s = 0; s < 40; s++) begin
            mode = 2'($urandom_range(3, 0));
            if ($urandom_range(1, 0) == 1) mode = 2'd2;
            run_seg(mode, $urandom_range(P - 1, 0), $urandom_range(50, 5),
                    ev_tab[$urandom_range(2, 0)]);
            if ($urandom_range(9, 0) == 0) async_reset();
        end
        repeat (4) drive(1'b0, 2'd0, 0);

        repeat (3) @(posedge CLK);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
